// File: rtl/ram_arbiter_pkg.sv
// Shared RAM device types plus the arbiter's state enum and latched-request struct.
// Device widths here are the codebase defaults; arbiter parameters must not exceed them.
package pkg_ram;

    localparam int RAM_ADDR_W = 32;
    localparam int RAM_DATA_W = 64;

    typedef enum logic [1:0] {
        RAM_NOP   = 2'd0,
        RAM_LOAD  = 2'd1,
        RAM_STORE = 2'd2
    } ram_op_t;

    typedef enum logic [1:0] {
        RAM_BYTE = 2'd0,
        RAM_HALF = 2'd1,
        RAM_WORD = 2'd2,
        RAM_LONG = 2'd3
    } ram_size_t;

    typedef enum logic [2:0] {
        ARB_BOOT,
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_ACK
    } arb_state_t;

    typedef struct packed {
        ram_op_t                 op;
        logic [RAM_ADDR_W-1:0]   addr;
        ram_size_t               size;
        logic [RAM_DATA_W-1:0]   data;
    } ram_req_t;

    function automatic ram_req_t make_req(input ram_op_t op, input logic [RAM_ADDR_W-1:0] addr,
                                          input ram_size_t size, input logic [RAM_DATA_W-1:0] data);
        ram_req_t r;
        r.op   = op;
        r.addr = addr;
        r.size = size;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// RAM device port: the driving side (loader, arbiter output) uses master, the RAM side slave.
interface if_dev_ram #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    import pkg_ram::*;

    ram_op_t            op;
    logic [ADDR_W-1:0]  addr;
    ram_size_t          size;
    logic [DATA_W-1:0]  data_in;

    modport master (output op, addr, size, data_in);
    modport slave  (input  op, addr, size, data_in);
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-requester round-robin picker: a lone request always wins, a tie goes to the
// requester that was not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       sel
);
    always_comb begin
        grant = |req;
        sel   = (req == 2'b11) ? ~last : req[1];
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares the RAM port between the boot loader (until boot_done) and two core masters,
// serving one core access at a time as a single RAM op followed by a one-cycle ack.
module ram_arbiter
    import pkg_ram::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boot_done,
    if_dev_ram.slave           boot,

    input  logic               m0_req,
    input  ram_op_t            m0_op,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  ram_size_t          m0_size,
    input  logic [DATA_W-1:0]  m0_wdata,
    output logic               m0_ack,
    output logic [DATA_W-1:0]  m0_rdata,

    input  logic               m1_req,
    input  ram_op_t            m1_op,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  ram_size_t          m1_size,
    input  logic [DATA_W-1:0]  m1_wdata,
    output logic               m1_ack,
    output logic [DATA_W-1:0]  m1_rdata,

    if_dev_ram.master          ram,
    input  logic [DATA_W-1:0]  ram_data_out
);

    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                r_last;
    logic                r_sel;
    logic [CNT_W-1:0]    r_cnt;
    ram_req_t            r_req;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_grant;
    logic                w_sel;
    logic                w_ack;
    ram_req_t            w_req0;
    ram_req_t            w_req1;
    ram_req_t            w_pick;

    assign w_req0 = make_req(m0_op, RAM_ADDR_W'(m0_addr), m0_size, RAM_DATA_W'(m0_wdata));
    assign w_req1 = make_req(m1_op, RAM_ADDR_W'(m1_addr), m1_size, RAM_DATA_W'(m1_wdata));
    assign w_pick = w_sel ? w_req1 : w_req0;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (r_last),
        .grant (w_grant),
        .sel   (w_sel)
    );

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= ARB_BOOT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        w_state_next = r_state;
        ram.op       = RAM_NOP;
        ram.addr     = r_req.addr[ADDR_W-1:0];
        ram.size     = r_req.size;
        ram.data_in  = r_req.data[DATA_W-1:0];
        case (r_state)
            ARB_BOOT: begin
                ram.op      = boot.op;
                ram.addr    = boot.addr;
                ram.size    = boot.size;
                ram.data_in = boot.data_in;
                if (boot_done) w_state_next = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (w_grant) w_state_next = (w_pick.op == RAM_NOP) ? ARB_ACK : ARB_ISSUE;
            end
            ARB_ISSUE: begin
                ram.op       = r_req.op;
                w_state_next = (r_req.op == RAM_LOAD) ? ARB_WAIT : ARB_ACK;
            end
            ARB_WAIT: begin
                if (r_cnt == '0) w_state_next = ARB_ACK;
            end
            ARB_ACK: begin
                w_state_next = ARB_IDLE;
            end
            default: w_state_next = ARB_BOOT;
        endcase
    end

    // Grant latch, load-latency countdown, read-data capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_cnt   <= '0;
            r_req   <= make_req(RAM_NOP, '0, RAM_BYTE, '0);
            r_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_sel <= w_sel;
                        r_req <= w_pick;
                    end
                end
                ARB_ISSUE: r_cnt <= CNT_W'(LOAD_LAT - 1);
                ARB_WAIT: begin
                    if (r_cnt == '0) r_rdata <= ram_data_out;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                ARB_ACK:  r_last <= r_sel;
                default: ;
            endcase
        end
    end

    assign w_ack    = (r_state == ARB_ACK);
    assign m0_ack   = w_ack & ~r_sel;
    assign m1_ack   = w_ack &  r_sel;
    assign m0_rdata = r_rdata;
    assign m1_rdata = r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: one arbiter with LOAD_LAT=1 for boot, fetch, NOP, contention and store,
// and one with LOAD_LAT=3 for reset in the middle of a load.
module tb_ram_arbiter;
    import pkg_ram::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst1, rst3, boot_done;
    logic              m0_req, m1_req;
    ram_op_t           m0_op, m1_op;
    logic [31:0]       m0_addr, m1_addr;
    ram_size_t         m0_size, m1_size;
    logic [63:0]       m0_wdata, m1_wdata;
    logic [63:0]       ram_data_out;

    logic              m0_ack1, m1_ack1, m0_ack3, m1_ack3;
    logic [63:0]       m0_rdata1, m1_rdata1, m0_rdata3, m1_rdata3;

    if_dev_ram #(.ADDR_W(32), .DATA_W(64)) boot_if ();
    if_dev_ram #(.ADDR_W(32), .DATA_W(64)) ram_if1 ();
    if_dev_ram #(.ADDR_W(32), .DATA_W(64)) ram_if3 ();

    ram_arbiter #(.ADDR_W(32), .DATA_W(64), .LOAD_LAT(1)) u_dut (
        .clk(clk), .rst(rst1), .boot_done(boot_done), .boot(boot_if),
        .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack1), .m0_rdata(m0_rdata1),
        .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack1), .m1_rdata(m1_rdata1),
        .ram(ram_if1), .ram_data_out(ram_data_out)
    );

    ram_arbiter #(.ADDR_W(32), .DATA_W(64), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .boot_done(boot_done), .boot(boot_if),
        .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack3), .m0_rdata(m0_rdata3),
        .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack3), .m1_rdata(m1_rdata3),
        .ram(ram_if3), .ram_data_out(ram_data_out)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Start of a cycle (inputs change here) and mid-cycle (outputs sampled here).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_boot(input ram_op_t op, input logic [31:0] addr, input logic [63:0] data);
        boot_if.op      = op;
        boot_if.addr    = addr;
        boot_if.size    = RAM_WORD;
        boot_if.data_in = data;
    endtask

    logic [31:0] exp_addr;
    logic [63:0] exp_data;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; boot_done = 1'b0;
        m0_req = 1'b0; m0_op = RAM_NOP; m0_addr = '0; m0_size = RAM_LONG; m0_wdata = '0;
        m1_req = 1'b0; m1_op = RAM_NOP; m1_addr = '0; m1_size = RAM_LONG; m1_wdata = '0;
        ram_data_out = 64'hDEAD_BEEF;
        drive_boot(RAM_STORE, 32'h5A, 64'h1234);

        // Reset state: no acks, zero rdata, RAM port follows the loader.
        repeat (2) cyc();
        mid();
        check("rst_m0_ack", 64'(m0_ack1), 64'd0);
        check("rst_m1_ack", 64'(m1_ack1), 64'd0);
        check("rst_m0_rdata", m0_rdata1, 64'd0);
        check("rst_m1_rdata", m1_rdata1, 64'd0);
        check("rst_ram_op", 64'(ram_if1.op), 64'(RAM_STORE));
        check("rst_ram_addr", 64'(ram_if1.addr), 64'h5A);

        // Boot pass-through with m0 already requesting; boot_done rises during the second store.
        cyc();
        rst1 = 1'b0;
        drive_boot(RAM_STORE, 32'h0, 64'h1010_0020);
        m0_req = 1'b1; m0_op = RAM_LOAD; m0_addr = 32'h8; m0_size = RAM_LONG;
        mid();
        check("boot0_op", 64'(ram_if1.op), 64'(RAM_STORE));
        check("boot0_addr", 64'(ram_if1.addr), 64'h0);
        check("boot0_data", ram_if1.data_in, 64'h1010_0020);
        check("boot0_m0_ack", 64'(m0_ack1), 64'd0);

        cyc();
        drive_boot(RAM_STORE, 32'h4, 64'h2021_0000);
        boot_done = 1'b1;
        mid();
        check("boot1_op", 64'(ram_if1.op), 64'(RAM_STORE));
        check("boot1_addr", 64'(ram_if1.addr), 64'h4);
        check("boot1_data", ram_if1.data_in, 64'h2021_0000);
        check("boot1_m0_ack", 64'(m0_ack1), 64'd0);

        // Single fetch: grant at t, LOAD at t+1, capture at t+2, ack at t+3.
        cyc();
        drive_boot(RAM_STORE, 32'hC, 64'hFFFF);
        mid();
        check("fetch_t_op", 64'(ram_if1.op), 64'(RAM_NOP));
        check("fetch_t_ack", 64'(m0_ack1), 64'd0);

        cyc();
        drive_boot(RAM_NOP, 32'h0, 64'h0);
        mid();
        check("fetch_t1_op", 64'(ram_if1.op), 64'(RAM_LOAD));
        check("fetch_t1_addr", 64'(ram_if1.addr), 64'h8);
        check("fetch_t1_size", 64'(ram_if1.size), 64'(RAM_LONG));
        check("fetch_t1_ack", 64'(m0_ack1), 64'd0);

        cyc();
        ram_data_out = 64'h6865_6C6C;
        mid();
        check("fetch_t2_op", 64'(ram_if1.op), 64'(RAM_NOP));
        check("fetch_t2_ack", 64'(m0_ack1), 64'd0);

        cyc();
        ram_data_out = 64'hDEAD_BEEF;
        m0_req = 1'b0;
        mid();
        check("fetch_t3_m0_ack", 64'(m0_ack1), 64'd1);
        check("fetch_t3_m0_rdata", m0_rdata1, 64'h6865_6C6C);
        check("fetch_t3_m1_ack", 64'(m1_ack1), 64'd0);

        // NOP request from m1: ack one cycle after the grant, no RAM op.
        cyc();
        m1_req = 1'b1; m1_op = RAM_NOP; m1_addr = 32'h70;
        mid();
        check("nop_t_op", 64'(ram_if1.op), 64'(RAM_NOP));
        check("nop_t_ack", 64'(m1_ack1), 64'd0);

        cyc();
        m1_req = 1'b0;
        mid();
        check("nop_t1_m1_ack", 64'(m1_ack1), 64'd1);
        check("nop_t1_m0_ack", 64'(m0_ack1), 64'd0);
        check("nop_t1_op", 64'(ram_if1.op), 64'(RAM_NOP));

        // Contention: last is now m1, so m0 must win first; then strict alternation.
        for (int g = 0; g < 4; g++) begin
            cyc();
            if (g == 0) begin
                m0_req = 1'b1; m0_op = RAM_STORE; m0_addr = 32'h40; m0_size = RAM_LONG; m0_wdata = 64'hA0;
                m1_req = 1'b1; m1_op = RAM_STORE; m1_addr = 32'h48; m1_size = RAM_LONG; m1_wdata = 64'hB1;
            end
            if (g == 3) m0_req = 1'b0;
            mid();
            check($sformatf("cont%0d_idle_op", g), 64'(ram_if1.op), 64'(RAM_NOP));
            check($sformatf("cont%0d_idle_ack", g), 64'({m1_ack1, m0_ack1}), 64'd0);

            exp_addr = (g % 2 == 0) ? 32'h40 : 32'h48;
            exp_data = (g % 2 == 0) ? 64'hA0 : 64'hB1;
            cyc();
            mid();
            check($sformatf("cont%0d_issue_op", g), 64'(ram_if1.op), 64'(RAM_STORE));
            check($sformatf("cont%0d_issue_addr", g), 64'(ram_if1.addr), 64'(exp_addr));
            check($sformatf("cont%0d_issue_data", g), ram_if1.data_in, exp_data);

            cyc();
            if (g == 3) m1_req = 1'b0;
            mid();
            check($sformatf("cont%0d_m0_ack", g), 64'(m0_ack1), (g % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("cont%0d_m1_ack", g), 64'(m1_ack1), (g % 2 == 1) ? 64'd1 : 64'd0);
        end

        // Data store from m1 alone, just after m1 was granted last.
        cyc();
        m1_req = 1'b1; m1_op = RAM_STORE; m1_addr = 32'h20; m1_size = RAM_WORD; m1_wdata = 64'h6F2C_2077;
        mid();
        check("store_t_op", 64'(ram_if1.op), 64'(RAM_NOP));

        cyc();
        mid();
        check("store_t1_op", 64'(ram_if1.op), 64'(RAM_STORE));
        check("store_t1_addr", 64'(ram_if1.addr), 64'h20);
        check("store_t1_data", ram_if1.data_in, 64'h6F2C_2077);
        check("store_t1_size", 64'(ram_if1.size), 64'(RAM_WORD));
        check("store_t1_ack", 64'(m1_ack1), 64'd0);

        cyc();
        m1_req = 1'b0;
        mid();
        check("store_t2_m1_ack", 64'(m1_ack1), 64'd1);
        check("store_t2_op", 64'(ram_if1.op), 64'(RAM_NOP));

        cyc();
        mid();
        check("store_t3_op", 64'(ram_if1.op), 64'(RAM_NOP));
        check("store_t3_ack", 64'(m1_ack1), 64'd0);

        // Reset mid-load on the LOAD_LAT=3 arbiter.
        cyc();
        rst1 = 1'b1; rst3 = 1'b0;
        m0_req = 1'b1; m0_op = RAM_LOAD; m0_addr = 32'h10; m0_size = RAM_LONG;
        mid();
        check("rml_boot_ack", 64'(m0_ack3), 64'd0);

        cyc();
        mid();
        check("rml_idle_op", 64'(ram_if3.op), 64'(RAM_NOP));

        cyc();
        mid();
        check("rml_issue_op", 64'(ram_if3.op), 64'(RAM_LOAD));
        check("rml_issue_addr", 64'(ram_if3.addr), 64'h10);

        cyc();
        ram_data_out = 64'h1111;
        mid();
        check("rml_wait_op", 64'(ram_if3.op), 64'(RAM_NOP));
        check("rml_wait_ack", 64'(m0_ack3), 64'd0);

        cyc();
        rst3 = 1'b1; boot_done = 1'b0;
        mid();
        check("rml_rst_ack", 64'(m0_ack3), 64'd0);

        cyc();
        rst3 = 1'b0;
        drive_boot(RAM_STORE, 32'h99, 64'h77);
        mid();
        check("rml_after_m0_ack", 64'(m0_ack3), 64'd0);
        check("rml_after_m1_ack", 64'(m1_ack3), 64'd0);
        check("rml_after_rdata", m0_rdata3, 64'd0);
        check("rml_after_op", 64'(ram_if3.op), 64'(RAM_STORE));
        check("rml_after_addr", 64'(ram_if3.addr), 64'h99);

        cyc();
        drive_boot(RAM_NOP, 32'h0, 64'h0);
        boot_done = 1'b1;
        mid();
        check("rml_boot2_ack", 64'(m0_ack3), 64'd0);

        cyc();
        mid();
        check("rml_regrant_op", 64'(ram_if3.op), 64'(RAM_NOP));

        cyc();
        mid();
        check("rml_reissue_op", 64'(ram_if3.op), 64'(RAM_LOAD));
        check("rml_reissue_addr", 64'(ram_if3.addr), 64'h10);

        for (int k = 0; k < 3; k++) begin
            cyc();
            ram_data_out = (k == 2) ? 64'h2F72_6C64 : 64'hBAD0;
            mid();
            check($sformatf("rml_wait%0d_ack", k), 64'(m0_ack3), 64'd0);
            check($sformatf("rml_wait%0d_op", k), 64'(ram_if3.op), 64'(RAM_NOP));
        end

        cyc();
        ram_data_out = 64'hBAD1;
        m0_req = 1'b0;
        mid();
        check("rml_ack", 64'(m0_ack3), 64'd1);
        check("rml_rdata", m0_rdata3, 64'h2F72_6C64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single RAM device port between the boot loader and the two ULM core masters: instruction fetch (m0) and data access (m1). While `boot_done` is low, the loader's `if_dev_ram` port passes straight through to the RAM and core requests are held off. After boot, the arbiter serves core requests one at a time with round-robin priority. It issues each access as a one-cycle RAM op and returns a one-cycle `ack`, which carries read data for loads.

## Interface
- `ADDR_W`, default 32: RAM byte-address width.
- `DATA_W`, default 64: RAM data width; matches `data_in` of `if_dev_ram`.
- `LOAD_LAT`, default 1: cycles from a `RAM_LOAD` op cycle to valid `ram_data_out`; must be ≥1.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `boot_done  in  1`: loader finished; expected to stay high once set until `rst`.
- `boot  in  if_dev_ram`: loader-side port with `op`, `addr`, `size`, `data_in`.
- `mN_req  in  1`, N=0,1: request; held high until `mN_ack`.
- `mN_op  in  pkg_ram op type`: `RAM_LOAD`, `RAM_STORE` or `RAM_NOP`.
- `mN_addr  in  ADDR_W`: access address.
- `mN_size  in  pkg_ram size type`: access size, e.g. `RAM_LONG`.
- `mN_wdata  in  DATA_W`: store data.
- `mN_ack  out  1`: one-cycle completion pulse.
- `mN_rdata  out  DATA_W`: load data; valid only while `mN_ack` is high.
- `ram  out  if_dev_ram`: RAM device port.
- `ram_data_out  in  DATA_W`: RAM read data.

## Operation
- State `BOOT`:
  - `ram.op`, `ram.addr`, `ram.size` and `ram.data_in` are a combinational copy of `boot`.
  - Core requests stay pending; no `ack` is given.
  - Leaves for `IDLE` on the first cycle `boot_done` is sampled high.
- State `IDLE`:
  - `ram.op` = `RAM_NOP`.
  - If any `req` is high, the arbiter picks a winner and latches that master's op, addr, size and wdata.
  - Goes to `ISSUE`, or to `ACK` if the latched op is `RAM_NOP`.
- Round robin:
  - A 1-bit `last` pointer records the most recently granted master.
  - With both requests high, the master that is not `last` wins.
  - With one request high, it wins regardless of `last`.
  - Reset sets `last` = 1, so m0 wins the first tie.
- State `ISSUE`:
  - Drives the latched op, addr, size and data onto `ram` for exactly one cycle.
  - A store goes to `ACK`.
  - A load goes to `WAIT` with a latency counter set to `LOAD_LAT`-1.
- State `WAIT`:
  - `ram.op` = `RAM_NOP`; the counter decrements each cycle.
  - When the counter reads 0, `ram_data_out` is captured into the rdata register and the state goes to `ACK`.
- State `ACK`:
  - Asserts the granted master's `ack` for one cycle; `rdata` holds the captured value.
  - Updates `last` to the granted master and returns to `IDLE`.
- Request rule: if a master's `req` is still high in the cycle after its `ack`, that is a new request. Latched fields are not re-sampled while a grant is in flight.
- The ungranted master keeps waiting with its inputs stable; no request is ever dropped.

## Timing
- Reset values:
  - State: `BOOT`, `last` = 1.
  - Both `ack` outputs 0 and both `rdata` outputs 0.
  - Latched op `RAM_NOP`; latched addr 0.
  - `ram` outputs follow `boot`.
- Cycle numbering: grant in `IDLE` at cycle t.
  - Store: `ram.op` = `RAM_STORE` at t+1, `ack` at t+2.
  - Load: `ram.op` = `RAM_LOAD` at t+1, data captured at t+1+`LOAD_LAT`, `ack` at t+2+`LOAD_LAT`.
  - NOP request: `ack` at t+1, no RAM cycle.
- Throughput:
  - Back-to-back stores from alternating masters: one op every 3 cycles.
  - Back-to-back loads: one op every 3+`LOAD_LAT` cycles.
- `boot_done` rising while the loader drives `RAM_STORE` in that same cycle: the store passes through. `IDLE` behaviour starts the next cycle.
- `rst` in any state (`ISSUE`, `WAIT`, `ACK`) aborts the access:
  - No `ack` follows.
  - The next cycle is `BOOT` with reset values.
  - A store that was already issued in `ISSUE` remains written in RAM.
- A request arriving in the `ACK` cycle waits for `IDLE`, so it is granted at the earliest one cycle later.

## Structure
- Shared in `pkg_ram`: op and size types (`RAM_NOP`, `RAM_LOAD`, `RAM_STORE`, `RAM_LONG`, ...).
- New in `pkg_ram`: an arbiter state enum (`ARB_BOOT`, `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_ACK`) and a request struct holding op, addr, size and data.
- Sub-module `rr_pick2`: a two-requester round-robin picker. Inputs `req[1:0]` and `last`; outputs `grant` and `sel`, combinational.
- Everything else lives in one module: state register, latency counter, latched request, rdata register.

## Test plan
- Boot pass-through: loader stores 32'h10100020 at addr 0 and 32'h20210000 at addr 4; m0_req held high throughout → both writes appear on `ram` unchanged, m0 gets no `ack` until after `boot_done`.
- Single fetch: m0 loads addr 8 with `LOAD_LAT`=1 and RAM returning 64'h68656C6C → `ram.op`=`RAM_LOAD` at t+1, `m0_ack` with `m0_rdata`=64'h68656C6C at t+3.
- Contention: m0 and m1 both request continuously → grant order m0, m1, m0, m1; neither master waits for more than one other access.
- Data store: m1 stores 64'h6F2C2077 at addr 32 → one `RAM_STORE` cycle at t+1, `m1_ack` at t+2, `ram.op` = `RAM_NOP` in every other cycle.
- Reset mid-load: `rst` asserted in `WAIT` with `LOAD_LAT`=3 → no `ack`, next cycle is `BOOT` with all outputs at reset values, and the m0 request is served again after `boot_done`.
- NOP request: m1 requests `RAM_NOP` → `m1_ack` at t+1, no op on `ram`, `last` updated to 1.
